gcd_param: RTL

GCD_PARAM -- requirements
Module: gcd_param

---
 rtl/gcd_param.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gcd_param.sv
// gcd_param: subtractive GCD engine behind a four-phase req/ack handshake.
// A is loaded on the first request and B on the second. CALC then takes one
// subtraction per cycle, and the result is presented on C while ack is high.
// Build option: define GCD_PARAM_STAT_EN to build the step counter and drive it
// onto iters. When the macro is undefined, iters is tied to zero and no counter
// is built.
// ack and C are registered copies of the decoded state, so they trail the
// state register by one clock. A result therefore appears two edges after the
// B-load edge when no subtraction is needed.
module gcd_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] AB,
  output logic             ack,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] iters
);

  typedef enum logic [2:0] {
    StIdleA = 3'd0,
    StLoadA = 3'd1,
    StIdleB = 3'd2,
    StCalc  = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] c_q, c_d;

  // Next-state and datapath: operand loads, one Euclid step per CALC cycle
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    case (state_q)
      StIdleA: begin
        if (req) begin
          a_d     = AB;
          state_d = StLoadA;
        end
      end
      StLoadA: begin
        if (!req) begin
          state_d = StIdleB;
        end
      end
      StIdleB: begin
        if (req) begin
          b_d     = AB;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // req is deliberately ignored here; only DONE looks at it again
        if ((a_q == '0) || (b_q == '0)) begin
          r_d     = a_q | b_q;
          state_d = StDone;
        end else if (a_q == b_q) begin
          r_d     = a_q;
          state_d = StDone;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      StDone: begin
        if (!req) begin
          state_d = StIdleA;
        end
      end
      default: begin
        // Unused encodings recover to the start of a transaction
        state_d = StIdleA;
      end
    endcase
  end

  // Output decode from the registered state only, never from req
  always_comb begin
    ack_d = (state_q == StLoadA) || (state_q == StDone);
    c_d   = (state_q == StDone) ? r_q : '0;
  end

  // State, operand, result and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdleA;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      ack_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      ack_q   <= ack_d;
      c_q     <= c_d;
    end
  end

  assign ack = ack_q;
  assign C   = c_q;

`ifdef GCD_PARAM_STAT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             cnt_clr;
  logic             cnt_step;

  // Step counter: cleared on the B load, bumped once per subtraction
  always_comb begin
    cnt_clr  = (state_q == StIdleB) && req;
    cnt_step = (state_q == StCalc) && (a_q != '0) && (b_q != '0) && (a_q != b_q);
    cnt_d    = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_step) begin
      // Step count never exceeds 2^WIDTH-2, so no saturation is needed
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Step counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign iters = cnt_q;
`else
  assign iters = '0;
`endif

endmodule
